seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter STEP, default 1, maximum bits shifted per cycle; SHALL be a power of two with 1 <= STEP <= WIDTH.
REQ-003 Parameter SHAMT_W, default $clog2(WIDTH), width of the shift-amount field.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  shifter can accept a request.
REQ-008 data_in  input  WIDTH  operand.
REQ-009 shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-010 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 data_out  output  WIDTH  result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be high only in IDLE; an accept SHALL occur on a rising edge where in_valid and in_ready are both high.
REQ-017 On accept, the block SHALL capture data_in into the working register, op into an op register, and shamt into a remaining counter, then go to SHIFT if shamt != 0, otherwise DONE.
REQ-018 On each edge in SHIFT, the block SHALL shift the working register by k = min(STEP, remaining) and decrement remaining by k.
REQ-019 The block SHALL move to DONE on the edge where remaining reaches 0.
REQ-020 Latency SHALL be ceil(shamt/STEP) cycles from the accept edge to out_valid high; with shamt = 0, out_valid SHALL be high in the cycle after the accept.
REQ-021 SLL SHALL fill vacated bits with 0.
REQ-022 SRL SHALL fill vacated bits with 0.
REQ-023 SRA SHALL fill vacated bits with the captured data_in[WIDTH-1] on every step.
REQ-024 ROR SHALL feed the bits shifted out of bit 0 back in at bit WIDTH-1.
REQ-025 After the final step, data_out SHALL equal the single-shot result for (data_in, shamt, op).
REQ-026 out_valid SHALL be high only in DONE; data_out SHALL hold the working register.
REQ-027 In DONE, data_out SHALL remain stable until out_ready is high; the edge where out_valid and out_ready are both high SHALL return the FSM to IDLE.
REQ-028 Input changes while busy SHALL be ignored.
REQ-029 No new request SHALL be accepted in the same cycle a result is consumed; one idle cycle follows each consume.
REQ-030 During SHIFT and IDLE, data_out SHALL hold the working register; consumers SHALL qualify it with out_valid.

Reset
REQ-031 Asserting reset_n low SHALL immediately, without waiting for a clock edge, force: IDLE, out_valid 0, busy 0, data_out 0, remaining 0, op register 00.
REQ-032 A reset in SHIFT or DONE SHALL abort the request with no result produced.
REQ-033 After reset_n rises, in_ready SHALL be high.

Structure
REQ-034 A shared package SHALL hold the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR) and the FSM state enum.
REQ-035 One combinational sub-module, shift_step, SHALL perform a single shift of 0..STEP bits for a given op and be instantiated once.
REQ-036 Counter arithmetic SHALL use SHAMT_W+1 bits so that min(STEP, remaining) does not overflow when STEP = WIDTH.

Verification
REQ-037 WIDTH=32, STEP=1: SRA of 0x80000000 by 1 -> data_out 0xC0000000, out_valid 1 cycle after accept.
REQ-038 SRL of 0xF0000000 by 4 -> 0x0F000000 after 4 cycles; ROR of 0x00000001 by 1 -> 0x80000000.
REQ-039 shamt = 0, SLL of 0x12345678 -> 0x12345678, with out_valid in the cycle after accept.
REQ-040 STEP=4: SLL of 0x00000001 by 31 -> 0x80000000 after 8 cycles; SRA of 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-041 Hold out_ready low for 5 cycles in DONE -> data_out stable, in_ready 0, busy 1; raise out_ready -> IDLE on the next edge.
REQ-042 Assert reset_n low mid-SHIFT, 3 steps into a 10-bit shift -> out_valid 0 and data_out 0 immediately, no result emitted; a new request is accepted after release.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: op encodings and FSM states.
package seq_shifter_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Single combinational shift of 0..STEP bits; the caller bounds amt.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    case (op)
      SHIFT_SLL: result = data << amt;
      SHIFT_SRL: result = data >> amt;
      // Fill comes from the sign captured at accept, not the current MSB.
      SHIFT_SRA: result = WIDTH'({{WIDTH{sign}}, data} >> amt);
      SHIFT_ROR: result = WIDTH'({data, data} >> amt);
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: IDLE accepts, SHIFT applies up to STEP bits per edge,
// DONE holds the result until consumed.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  // One extra bit so STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [1:0]         op_r;
  logic [SHAMT_W:0]   rem;
  logic [SHAMT_W:0]   k;
  logic               sign;
  logic [WIDTH-1:0]   stepped;

  assign k = (rem > STEP_C) ? STEP_C : rem;

  shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (SHAMT_W+1)
  ) u_step (
    .data   (work),
    .op     (op_r),
    .amt    (k),
    .sign   (sign),
    .result (stepped)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      work  <= '0;
      op_r  <= SHIFT_SLL;
      rem   <= '0;
      sign  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          work  <= data_in;
          op_r  <= op;
          rem   <= {1'b0, shamt};
          sign  <= data_in[WIDTH-1];
          state <= (shamt != '0) ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          work <= stepped;
          rem  <= rem - k;
          if (rem == k) state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign data_out  = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: STEP=1 and STEP=4 instances, one task per scenario.
module tb_seq_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  op = '0;
  logic        out_ready = 1'b0;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1, busy1;
  logic [31:0] data_out1;
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, busy4;
  logic [31:0] data_out4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_in(data_in), .shamt(shamt), .op(op), .out_valid(out_valid1),
    .out_ready(out_ready), .data_out(data_out1), .busy(busy1));

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .data_in(data_in), .shamt(shamt), .op(op), .out_valid(out_valid4),
    .out_ready(out_ready), .data_out(data_out4), .busy(busy4));

  // Accept one request, return cycles from accept edge to out_valid (-1 on timeout).
  task automatic issue(input bit s4, input logic [31:0] d, input logic [4:0] sa,
                       input logic [1:0] o, output int lat, output logic [31:0] res);
    @(posedge clock); #1;
    data_in = d; shamt = sa; op = o;
    if (s4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clock); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    lat = 0;
    while (!(s4 ? out_valid4 : out_valid1) && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!(s4 ? out_valid4 : out_valid1)) lat = -1;
    res = s4 ? data_out4 : data_out1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || data_out1 !== 32'h0) begin
      errors++; $display("FAIL reset_during: ov=%b busy=%b dout=%h want 0 0 0", out_valid1, busy1, data_out1);
    end
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready1, in_ready4);
    end
    checks++; if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || data_out4 !== 32'h0) begin
      errors++; $display("FAIL reset_state4: ov=%b busy=%b dout=%h want 0 0 0", out_valid4, busy4, data_out4);
    end
  endtask

  // One directed vector: compare result and latency, then consume.
  task automatic test_vector(input string name, input bit s4, input logic [31:0] d,
                             input logic [4:0] sa, input logic [1:0] o,
                             input logic [31:0] exp_d, input int exp_lat);
    int lat;
    logic [31:0] res;
    issue(s4, d, sa, o, lat, res);
    checks++; if (res !== exp_d) begin
      errors++; $display("FAIL %s_data: got %h want %h", name, res, exp_d);
    end
    checks++; if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    consume();
  endtask

  task automatic test_ops();
    test_vector("sra1",     1'b0, 32'h80000000, 5'd1,  2'b10, 32'hC0000000, 1);
    test_vector("srl4",     1'b0, 32'hF0000000, 5'd4,  2'b01, 32'h0F000000, 4);
    test_vector("ror1",     1'b0, 32'h00000001, 5'd1,  2'b11, 32'h80000000, 1);
    test_vector("shamt0",   1'b0, 32'h12345678, 5'd0,  2'b00, 32'h12345678, 0);
    test_vector("sll3",     1'b0, 32'h0000000F, 5'd3,  2'b00, 32'h00000078, 3);
  endtask

  task automatic test_step4();
    test_vector("s4_sll31", 1'b1, 32'h00000001, 5'd31, 2'b00, 32'h80000000, 8);
    test_vector("s4_sra31", 1'b1, 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 8);
    test_vector("s4_ror8",  1'b1, 32'h12345678, 5'd8,  2'b11, 32'h78123456, 2);
    test_vector("s4_srl5",  1'b1, 32'hF0000000, 5'd5,  2'b01, 32'h07800000, 2);
    test_vector("s4_sra2p", 1'b1, 32'h40000000, 5'd2,  2'b10, 32'h10000000, 1);
  endtask

  // Stall in DONE with new inputs pending; they must be ignored and not accepted on consume.
  task automatic test_hold();
    int lat;
    logic [31:0] res;
    issue(1'b0, 32'h000000A5, 5'd2, 2'b00, lat, res);
    data_in = 32'hDEADBEEF; shamt = 5'd7; op = 2'b01; in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++; if (data_out1 !== 32'h00000294 || out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || busy1 !== 1'b1) begin
        errors++; $display("FAIL hold_%0d: dout=%h ov=%b ir=%b busy=%b want 00000294 1 0 1",
                           i, data_out1, out_valid1, in_ready1, busy1);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL hold_release: ov=%b busy=%b ir=%b want 0 0 1", out_valid1, busy1, in_ready1);
    end
    in_valid1 = 1'b0;
  endtask

  // Reset three steps into a 10-bit shift aborts it without a result.
  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    bit seen;
    @(posedge clock); #1;
    data_in = 32'hFFFFFFFF; shamt = 5'd10; op = 2'b01; in_valid1 = 1'b1;
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0 || data_out1 !== 32'h0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: ov=%b dout=%h busy=%b want 0 0 0", out_valid1, data_out1, busy1);
    end
    @(posedge clock); #3;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (out_valid1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_abort: result_seen=%b ir=%b want 0 1", seen, in_ready1);
    end
    issue(1'b0, 32'hF0000000, 5'd4, 2'b01, lat, res);
    checks++; if (res !== 32'h0F000000 || lat !== 4) begin
      errors++; $display("FAIL post_reset_req: dout=%h lat=%0d want 0f000000 4", res, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_step4();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
